// File: rtl/rv32im_bus_ram.sv
// Word-addressed bus RAM slave: byte-lane writes, programmable wait states,
// and error responses for out-of-range addresses or unsupported lane patterns.
module rv32im_bus_ram #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned BASE_WORD   = 0,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic [XLEN-1:0] slave_dat_i,
  output logic [XLEN-1:0] slave_dat_o,
  input  logic [XLEN-3:0] adr_i,
  input  logic [3:0]      sel_i,
  input  logic            stb_i,
  input  logic            we_i,
  output logic            ack_o,
  output logic            err_o
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic [XLEN-3:0] adr_q;
  logic [3:0]      sel_q;
  logic            we_q;
  logic [XLEN-1:0] dat_q;

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  logic [XLEN-3:0] cur_adr;
  logic [3:0]      cur_sel;
  logic            cur_we;
  logic [XLEN-1:0] cur_dat;
  logic [63:0]     adr_off;
  logic            in_range;
  logic            sel_ok;
  logic            req_ok;
  logic            finishing;
  logic            mem_we;
  logic [AW-1:0]   idx;

  // With zero wait states the request completes on its accepting edge, so the
  // live bus signals are used there; otherwise the latched copy is used.
  always_comb begin
    cur_adr   = (state == IDLE) ? adr_i       : adr_q;
    cur_sel   = (state == IDLE) ? sel_i       : sel_q;
    cur_we    = (state == IDLE) ? we_i        : we_q;
    cur_dat   = (state == IDLE) ? slave_dat_i : dat_q;
    // Offset underflows to a huge value when below BASE_WORD, so one compare covers both bounds.
    adr_off   = 64'(cur_adr) - 64'(BASE_WORD);
    in_range  = adr_off < 64'(DEPTH_WORDS);
    idx       = adr_off[AW-1:0];
    sel_ok    = cur_sel inside {4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                4'b0011, 4'b1100, 4'b1111};
    req_ok    = in_range && sel_ok;
    finishing = stb_i && (((state == IDLE) && (WAIT_STATES == 0)) ||
                          ((state == WAIT) && (cnt == 4'd1)));
    mem_we    = !reset_i && finishing && req_ok && cur_we;
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (cur_sel[b]) mem[idx][8*b +: 8] <= cur_dat[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state       <= IDLE;
      cnt         <= '0;
      ack_o       <= 1'b0;
      err_o       <= 1'b0;
      slave_dat_o <= '0;
      adr_q       <= '0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      dat_q       <= '0;
    end else begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (stb_i) begin
            adr_q <= adr_i;
            sel_q <= sel_i;
            we_q  <= we_i;
            dat_q <= slave_dat_i;
            cnt   <= 4'(WAIT_STATES);
            state <= (WAIT_STATES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (!stb_i) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) state <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (finishing) begin
        if (!req_ok) begin
          err_o <= 1'b1;
        end else begin
          ack_o <= 1'b1;
          if (!cur_we) slave_dat_o <= mem[idx];
        end
      end
    end
  end

endmodule
